// File: rtl/nv_nvdla_sdp_wdma_gpack.sv
// Gathers IW-bit (or half/quarter precision) beats into one OW-bit word.
// A word closes after N beats or early on inp_last; unfilled segments read as zero.
module nv_nvdla_sdp_wdma_gpack #(
  parameter int IW    = 256,
  parameter int RATIO = 2,
  parameter int OW    = IW * RATIO
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic [1:0]    cfg_mode,
  input  logic          inp_pvld,
  output logic          inp_prdy,
  input  logic [IW-1:0] inp_data,
  input  logic          inp_last,
  output logic          out_pvld,
  input  logic          out_prdy,
  output logic [OW-1:0] out_data,
  output logic [5:0]    out_beats,
  output logic          out_last,
  output logic          busy
);

  localparam int SW = $clog2(OW) + 1;

  logic [4:0]    r_cnt;
  logic [1:0]    r_mode;
  logic [OW-1:0] r_acc;
  logic          r_out_pvld;
  logic [OW-1:0] r_out_data;
  logic [5:0]    r_out_beats;
  logic          r_out_last;

  logic [1:0]    w_mode;
  logic [5:0]    w_nm1;
  logic [SW-1:0] w_bsz;
  logic [SW-1:0] w_shift;
  logic [IW-1:0] w_mask;
  logic [OW-1:0] w_merge;
  logic          w_closing;
  logic          w_accept;

  // Beat 0 uses the live cfg_mode (it is the value being captured); later beats use the latched one.
  assign w_mode    = (r_cnt != 5'd0) ? r_mode : ((cfg_mode == 2'd3) ? 2'd0 : cfg_mode);
  assign w_nm1     = (6'(RATIO) << w_mode) - 6'd1;
  assign w_bsz     = SW'(IW) >> w_mode;
  assign w_shift   = SW'(r_cnt) * w_bsz;
  assign w_mask    = ~({IW{1'b1}} << w_bsz);
  assign w_merge   = r_acc | (OW'(inp_data & w_mask) << w_shift);
  assign w_closing = ({1'b0, r_cnt} == w_nm1) | inp_last;
  assign inp_prdy  = !w_closing | !r_out_pvld | out_prdy;
  assign w_accept  = inp_pvld & inp_prdy;

  // Accumulation stage: count, latched mode and partial word.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_cnt  <= 5'd0;
      r_mode <= 2'd0;
      r_acc  <= '0;
    end else if (w_accept) begin
      if (r_cnt == 5'd0) r_mode <= w_mode;
      if (w_closing) begin
        r_cnt <= 5'd0;
        r_acc <= '0;
      end else begin
        r_cnt <= r_cnt + 5'd1;
        r_acc <= w_merge;
      end
    end
  end

  // Output register stage: a closing accept reloads even while the old word drains (no bubble).
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_out_pvld  <= 1'b0;
      r_out_data  <= '0;
      r_out_beats <= 6'd0;
      r_out_last  <= 1'b0;
    end else if (w_accept && w_closing) begin
      r_out_pvld  <= 1'b1;
      r_out_data  <= w_merge;
      r_out_beats <= 6'(r_cnt) + 6'd1;
      r_out_last  <= inp_last;
    end else if (out_prdy) begin
      r_out_pvld  <= 1'b0;
    end
  end

  assign out_pvld  = r_out_pvld;
  assign out_data  = r_out_data;
  assign out_beats = r_out_beats;
  assign out_last  = r_out_last;
  assign busy      = (r_cnt != 5'd0) | r_out_pvld;

endmodule
